// File: rtl/reg_6bit.sv
// Parallel-load data register with status outputs.
// Tracks previous value, change flag, parity and zero detect.
module reg_6bit #(
    parameter int              WIDTH   = 6,
    parameter logic [WIDTH-1:0] RST_VAL = '0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] I,
    output logic [WIDTH-1:0] A,
    output logic [WIDTH-1:0] A_prev,
    output logic             changed,
    output logic             parity,
    output logic             zero
);

    always_ff @(posedge clk) begin
        if (rst) begin
            A       <= RST_VAL;
            A_prev  <= RST_VAL;
            changed <= 1'b0;
        end else begin
            A_prev  <= A;
            A       <= I;
            changed <= (I != A);
        end
    end

    // Status depends only on registered A, so it never follows I glitches.
    always_comb begin
        parity = ^A;
        zero   = (A == '0);
    end

endmodule

// File: tb/tb_reg_6bit.sv
// Self-checking bench for reg_6bit.
// Directed vector table, glitch sequence and randomized model check.
module tb_reg_6bit;

    logic       clk;
    logic       rst;
    logic [5:0] I;
    logic [5:0] A;
    logic [5:0] A_prev;
    logic       changed;
    logic       parity;
    logic       zero;

    int checks   = 0;
    int failures = 0;

    reg_6bit dut (
        .clk    (clk),
        .rst    (rst),
        .I      (I),
        .A      (A),
        .A_prev (A_prev),
        .changed(changed),
        .parity (parity),
        .zero   (zero)
    );

    initial clk = 1'b0;
    always #20 clk = ~clk;

    typedef struct {
        bit       r;
        bit [5:0] i;
        bit [5:0] a;
        bit [5:0] prev;
        bit       chg;
        bit       par;
        bit       zr;
    } vec_t;

    vec_t tbl[13];

    task automatic chk(input string nm, input int act, input int exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic step(input bit r, input bit [5:0] v);
        @(negedge clk);
        #5;
        rst = r;
        I   = v;
        @(posedge clk);
        #1;
    endtask

    task automatic chk_all(input string tag, input int a, input int p,
                           input int c);
        int pe;
        int ze;
        pe = $countones(a) % 2;
        ze = (a == 0) ? 1 : 0;
        chk({tag, ".A"}, int'(A), a);
        chk({tag, ".A_prev"}, int'(A_prev), p);
        chk({tag, ".changed"}, int'(changed), c);
        chk({tag, ".parity"}, int'(parity), pe);
        chk({tag, ".zero"}, int'(zero), ze);
    endtask

    int m_a;
    int m_prev;
    int m_chg;

    initial begin
        rst = 1'b1;
        I   = 6'd45;

        //        r  i   a   prev chg par zr
        tbl[0]  = '{1, 45,  0,  0, 0, 0, 1};
        tbl[1]  = '{1, 45,  0,  0, 0, 0, 1};
        tbl[2]  = '{0, 63, 63,  0, 1, 0, 0};
        tbl[3]  = '{0, 21, 21, 63, 1, 1, 0};
        tbl[4]  = '{0, 34, 34, 21, 1, 0, 0};
        tbl[5]  = '{0, 34, 34, 34, 0, 0, 0};
        tbl[6]  = '{0, 34, 34, 34, 0, 0, 0};
        tbl[7]  = '{0, 34, 34, 34, 0, 0, 0};
        tbl[8]  = '{0, 21, 21, 34, 1, 1, 0};
        tbl[9]  = '{1, 63,  0,  0, 0, 0, 1};
        tbl[10] = '{0, 63, 63,  0, 1, 0, 0};
        tbl[11] = '{0,  0,  0, 63, 1, 0, 1};
        tbl[12] = '{0, 63, 63,  0, 1, 0, 0};

        for (int k = 0; k < 13; k++) begin
            step(tbl[k].r, tbl[k].i);
            chk($sformatf("vec%0d.A", k), int'(A), int'(tbl[k].a));
            chk($sformatf("vec%0d.A_prev", k), int'(A_prev), int'(tbl[k].prev));
            chk($sformatf("vec%0d.changed", k), int'(changed), int'(tbl[k].chg));
            chk($sformatf("vec%0d.parity", k), int'(parity), int'(tbl[k].par));
            chk($sformatf("vec%0d.zero", k), int'(zero), int'(tbl[k].zr));
        end

        // Glitching I between edges must not disturb A.
        @(negedge clk);
        #5;  I = 6'd5;
        #3;  I = 6'd10;
        #3;  I = 6'd5;
        chk("glitch.A_mid", int'(A), 63);
        chk("glitch.zero_mid", int'(zero), 0);
        #3;  I = 6'd7;
        @(posedge clk);
        #1;
        chk_all("glitch", 7, 63, 1);

        // Randomized run against an arithmetic model.
        m_a    = 7;
        m_prev = 63;
        m_chg  = 1;
        for (int k = 0; k < 300; k++) begin
            bit       r;
            bit [5:0] v;
            r = ($urandom_range(15) == 0);
            v = 6'($urandom_range(63));
            if (k % 7 == 3)
                v = 6'(m_a);
            step(r, v);
            if (r) begin
                m_a    = 0;
                m_prev = 0;
                m_chg  = 0;
            end else begin
                m_chg  = (int'(v) != m_a) ? 1 : 0;
                m_prev = m_a;
                m_a    = int'(v);
            end
            chk_all($sformatf("rnd%0d", k), m_a, m_prev, m_chg);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/reg_6bit.md
Name: reg_6bit

Overview:
- Clocked parallel-load data register, WIDTH bits wide (default 6).
- Captures input word I on every rising clock edge and presents it on A.
- Provides status outputs for downstream logic: previous value, change flag, parity and zero flag.
- Used as a pipeline or holding register between combinational stages.

Parameters:
- WIDTH, 6, data width of I, A and A_prev; legal range 1..32.
- RST_VAL, 0, value loaded into A and A_prev by reset; WIDTH bits.

Ports:
- clk  input  1  system clock; all state updates on the rising edge.
- rst  input  1  reset; synchronous, active-high.
- I  input  WIDTH  parallel data input.
- A  output  WIDTH  registered data output.
- A_prev  output  WIDTH  value A held before the most recent load.
- changed  output  1  high for one cycle when the most recent load altered A.
- parity  output  1  even parity of A (XOR-reduce of A); combinational from A.
- zero  output  1  high when A equals all zeros; combinational from A.

Behaviour:
- Single clock domain (clk); reset is synchronous and active-high (rst). No asynchronous paths.
- Reset takes priority over load. On a rising edge with rst=1:
  - A <= RST_VAL, A_prev <= RST_VAL, changed <= 0.
  - I is ignored.
- Load happens on every rising edge with rst=0; there is no enable:
  - A_prev <= A (old value); A <= I.
  - changed <= (I != A), comparing the sampled I against the pre-edge A.
- Latency is one edge: a value applied to I before edge n appears on A immediately after edge n. It holds until edge n+1.
- I is sampled only at rising edges. Changes on I between edges have no effect on any output.
- parity and zero are purely combinational functions of the registered A and are glitch-free with respect to I.
  - After reset with RST_VAL=0: parity=0, zero=1.
- Reloading the same value gives A unchanged, A_prev = A, changed=0.
- Reset asserted mid-stream takes effect on the next edge regardless of I. Deassertion resumes loading on the following edge with no extra wait cycle.
- Before the first rising edge with rst=1, output values are undefined.
  - Integrators assert rst for at least one edge, or accept that the first load defines A.
- Widths are exact: no sign extension or truncation. All comparisons are unsigned, WIDTH bits.
- Implementation: all state in one clocked process; status outputs in a separate combinational block.

Test Plan:
- Reset: hold rst=1 across two edges with I=6'd45 -> A=0, A_prev=0, changed=0, zero=1, parity=0.
- Load sequence (20 ns half-period, I updated 5 ns after each falling edge): I=63, 21, 34 on successive edges.
  - A=63, then 21, then 34.
  - A_prev=0, then 63, then 21.
  - changed=1 each cycle.
  - parity 0, 1, 0; zero=0.
- Hold: keep I=34 for three edges -> A stays 34, A_prev=34, changed=0 after the first repeat.
- Mid-cycle glitch: toggle I between 5 and 10 away from edges, settle to 7 before the edge -> A changes only at the edge, to 7.
- Reset mid-operation: A=21, assert rst for one edge with I=63 -> A=0. Deassert rst, next edge with I=63 -> A=63, A_prev=0, changed=1.
- Boundary values: load 0 then 63 -> zero=1 then 0; parity 0 then 0; changed=1 on the second load.
